sram_bank_ctrl: RTL and testbench



---
 rtl/sram_bank_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sram_bank_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: tiles SHPA110_1024X1X32BM1 macros (1024 x 32) into a
// WORDS x BITS single-port synchronous memory with a valid/ready request
// port, a one-cycle read response backed by a hold register, out-of-range
// detection and an optional post-reset zero-clear sequencer.
//
// Optional feature macro: SRAM_BANK_CTRL_INIT_EN
//   defined   : after reset every word is written to zero (WORDS cycles)
//               before req_ready/init_done rise.
//   undefined : ready one cycle after reset release, contents undefined.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake (accept on valid & ready)
//   req_wen             1 = write, 0 = read
//   req_adress          word address (bank = [AW-1:10], row = [9:0])
//   req_din, req_mask   write data and per-bit write enable
//   rsp_valid           read data valid (cycle after the accept edge)
//   rsp_dout            read data, holds last delivered value otherwise
//   rsp_err             with rsp_valid: read address was out of range
//   init_done           memory usable
//
// The file also carries a behavioural model of the hard macro so the
// controller can be simulated stand-alone; OE=1 freezes the DO register.

module SHPA110_1024X1X32BM1 (
  input  logic        CLK,
  input  logic        CS,
  input  logic        OE,
  input  logic [9:0]  A,
  input  logic [31:0] DI,
  input  logic [31:0] WEB,
  output logic [31:0] DO
);
  logic [31:0] mem [1024];

  always_ff @(posedge CLK) begin
    if (CS) begin
      if (~&WEB) mem[A] <= (mem[A] & WEB) | (DI & ~WEB);
      if (&WEB && !OE) DO <= mem[A];
    end
  end
endmodule

module sram_bank_ctrl #(
  parameter int BITS         = 32,
  parameter int WORDS        = 2048,
  parameter int ADRESS_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADRESS_WIDTH-1:0] req_adress,
  input  logic [BITS-1:0]         req_din,
  input  logic [BITS-1:0]         req_mask,
  output logic                    rsp_valid,
  output logic [BITS-1:0]         rsp_dout,
  output logic                    rsp_err,
  output logic                    init_done
);
  localparam int COLS   = BITS / 32;
  localparam int BANKS  = (WORDS + 1023) / 1024;
  localparam int AW_EXT = ADRESS_WIDTH + 1;

  typedef enum logic [1:0] {INIT, DONE_WAIT, IDLE} state_t;
  state_t state;

  logic                    accept;
  logic [ADRESS_WIDTH-1:0] mem_addr;
  logic                    mem_wen;
  logic                    mem_en;
  logic [BITS-1:0]         mem_din;
  logic [BITS-1:0]         mem_mask;
  logic [BITS-1:0]         web;
  logic [ADRESS_WIDTH-1:0] bank;
  logic [9:0]              row;
  logic                    in_range;
  logic [ADRESS_WIDTH-1:0] bank_q;
  logic [BITS-1:0]         hold_q;
  logic [BITS-1:0]         bank_do [BANKS];
  logic [BITS-1:0]         sel_do;
`ifdef SRAM_BANK_CTRL_INIT_EN
  logic [ADRESS_WIDTH-1:0] clr_cnt;
`endif

  assign accept = req_valid & req_ready;

  // The clear sequencer borrows the request path while in INIT.
  always_comb begin
    mem_addr = req_adress;
    mem_wen  = req_wen;
    mem_din  = req_din;
    mem_mask = req_mask;
    mem_en   = accept;
`ifdef SRAM_BANK_CTRL_INIT_EN
    if (state == INIT) begin
      mem_addr = clr_cnt;
      mem_wen  = 1'b1;
      mem_din  = '0;
      mem_mask = '1;
      mem_en   = 1'b1;
    end
`endif
  end

  assign bank     = mem_addr >> 10;
  assign row      = mem_addr[9:0];
  assign in_range = {1'b0, mem_addr} < AW_EXT'(WORDS);
  assign web      = ~({BITS{mem_wen}} & mem_mask);

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic            cs;
    logic [BITS-1:0] dout;
    assign cs = mem_en & in_range & (bank == ADRESS_WIDTH'(b));
    for (genvar c = 0; c < COLS; c++) begin : g_col
      SHPA110_1024X1X32BM1 u_macro (
        .CLK (clk),
        .CS  (cs),
        .OE  (1'b0),
        .A   (row),
        .DI  (mem_din[c*32 +: 32]),
        .WEB (web[c*32 +: 32]),
        .DO  (dout[c*32 +: 32])
      );
    end
    assign bank_do[b] = dout;
  end

  always_comb begin
    sel_do = '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      if (bank_q == ADRESS_WIDTH'(b)) sel_do = bank_do[b];
    end
  end

  // Macro DO is live only in the response cycle; afterwards the hold
  // register presents the last delivered value.
  assign rsp_dout = rsp_valid ? (rsp_err ? '0 : sel_do) : hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef SRAM_BANK_CTRL_INIT_EN
      state   <= INIT;
      clr_cnt <= '0;
`else
      state   <= DONE_WAIT;
`endif
      req_ready <= 1'b0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      bank_q    <= '0;
      hold_q    <= '0;
    end else begin
      rsp_valid <= accept & ~req_wen;
      rsp_err   <= accept & ~req_wen & ~in_range;
      if (accept) bank_q <= bank;
      if (rsp_valid) hold_q <= rsp_dout;
      case (state)
`ifdef SRAM_BANK_CTRL_INIT_EN
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADRESS_WIDTH'(WORDS - 1)) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
`endif
        DONE_WAIT: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Self-checking bench for sram_bank_ctrl: a 2048 x 32 instance (12-bit
// address so out-of-range words are reachable) and a 1024 x 64 instance.
// Honours SRAM_BANK_CTRL_INIT_EN when the build defines it.
module tb_sram_bank_ctrl;
  localparam int W  = 2048;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_wen;
  logic [AW-1:0] req_adress;
  logic [31:0]   req_din, req_mask, rsp_dout;
  logic          rsp_valid, rsp_err, init_done;

  logic        r64_valid, r64_ready, r64_wen, r64_rvalid, r64_err, r64_done;
  logic [9:0]  r64_adr;
  logic [63:0] r64_din, r64_mask, r64_dout;

  sram_bank_ctrl #(.BITS(32), .WORDS(W), .ADRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_adress(req_adress), .req_din(req_din),
    .req_mask(req_mask), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
    .rsp_err(rsp_err), .init_done(init_done));

  sram_bank_ctrl #(.BITS(64), .WORDS(1024), .ADRESS_WIDTH(10)) dut64 (
    .clk(clk), .rst(rst), .req_valid(r64_valid), .req_ready(r64_ready),
    .req_wen(r64_wen), .req_adress(r64_adr), .req_din(r64_din),
    .req_mask(r64_mask), .rsp_valid(r64_rvalid), .rsp_dout(r64_dout),
    .rsp_err(r64_err), .init_done(r64_done));

  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [W];
  logic [31:0] last_dout;

  typedef struct {
    logic          wen;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [31:0]   m;
    logic          ev;
    logic          ee;
    logic [31:0]   ed;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [31:0] m);
    req_valid = v; req_wen = w; req_adress = a; req_din = d; req_mask = m;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Reference: word array, masked merge on in-range writes, reads return the
  // stored word (zero for out-of-range), idle cycles show the last read.
  task automatic model(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [31:0] m,
                       output logic ev, output logic ee, output logic [31:0] ed);
    ev = 1'b0; ee = 1'b0;
    if (v && !w) begin
      ev = 1'b1;
      ee = (int'(a) >= W);
      last_dout = ee ? 32'h0 : ref_mem[a[10:0]];
    end else if (v && w && int'(a) < W) begin
      ref_mem[a[10:0]] = (ref_mem[a[10:0]] & ~m) | (d & m);
    end
    ed = last_dout;
  endtask

  task automatic op(input string name, input logic v, input logic w, input logic [AW-1:0] a,
                    input logic [31:0] d, input logic [31:0] m);
    logic ev, ee;
    logic [31:0] ed;
    drive(v, w, a, d, m);
    model(v, w, a, d, m, ev, ee, ed);
    check({name, "_valid"}, 64'(rsp_valid), 64'(ev));
    if (ev) check({name, "_err"}, 64'(rsp_err), 64'(ee));
    check({name, "_dout"}, 64'(rsp_dout), 64'(ed));
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int n = 0;
    while (!req_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_cycles"}, 64'(n), 64'(exp_cycles));
    check({name, "_init_done"}, 64'(init_done), 64'd1);
  endtask

  task automatic op64(input string name, input logic w, input logic [9:0] a,
                      input logic [63:0] d, input logic [63:0] m,
                      input logic ev, input logic [63:0] ed);
    r64_valid = 1'b1; r64_wen = w; r64_adr = a; r64_din = d; r64_mask = m;
    @(posedge clk); #1;
    r64_valid = 1'b0;
    check({name, "_valid"}, 64'(r64_rvalid), 64'(ev));
    if (ev) begin
      check({name, "_err"}, 64'(r64_err), 64'd0);
      check({name, "_dout"}, r64_dout, ed);
    end
  endtask

`ifdef SRAM_BANK_CTRL_INIT_EN
  localparam int INIT_CYCLES = W;
`else
  localparam int INIT_CYCLES = 1;
`endif

  initial begin
    req_valid = 1'b0; req_wen = 1'b0; req_adress = '0; req_din = '0; req_mask = '0;
    r64_valid = 1'b0; r64_wen = 1'b0; r64_adr = '0; r64_din = '0; r64_mask = '0;
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    last_dout = 32'h0;

    // Reset with a write presented throughout: it must be ignored.
    rst = 1'b1;
    req_valid = 1'b1; req_wen = 1'b1; req_adress = 12'h005; req_din = 32'h5555_5555; req_mask = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    check("rst_dout", 64'(rsp_dout), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    rst = 1'b0;
    wait_ready("init", INIT_CYCLES);
    req_valid = 1'b0;
    check("ready64", 64'(r64_ready), 64'd1);

    // 64-bit, two-column instance.
    op64("w64_full", 1'b1, 10'h3FF, 64'h0123_4567_89AB_CDEF, '1, 1'b0, '0);
    op64("r64_full", 1'b0, 10'h3FF, '0, '0, 1'b1, 64'h0123_4567_89AB_CDEF);
    op64("w64_hi", 1'b1, 10'h3FF, '1, 64'hFFFF_FFFF_0000_0000, 1'b0, '0);
    op64("r64_hi", 1'b0, 10'h3FF, '0, '0, 1'b1, 64'hFFFF_FFFF_89AB_CDEF);

`ifndef SRAM_BANK_CTRL_INIT_EN
    // Without the clear sequencer, give every word a known zero.
    for (int a = 0; a < W; a++) drive(1'b1, 1'b1, AW'(a), 32'h0, '1);
`endif

    vecs = '{
      '{1'b0, 12'h000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0000},
      '{1'b0, 12'h3FF, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0000},
      '{1'b0, 12'h400, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0000},
      '{1'b0, 12'h7FF, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0000},
      '{1'b1, 12'h7FF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000},
      '{1'b0, 12'h7FF, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF},
      '{1'b0, 12'h3FF, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0000},
      '{1'b1, 12'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000},
      '{1'b1, 12'h005, 32'h1234_5678, 32'h0000_FFFF, 1'b0, 1'b0, 32'h0000_0000},
      '{1'b0, 12'h005, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFF_5678},
      '{1'b1, 12'h800, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_5678},
      '{1'b0, 12'h800, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0000},
      '{1'b0, 12'h000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0000},
      '{1'b0, 12'h7FF, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF}
    };
    for (int i = 0; i < vecs.size(); i++) begin
      logic ev, ee;
      logic [31:0] ed;
      drive(1'b1, vecs[i].wen, vecs[i].a, vecs[i].d, vecs[i].m);
      model(1'b1, vecs[i].wen, vecs[i].a, vecs[i].d, vecs[i].m, ev, ee, ed);
      check($sformatf("vec%0d_valid", i), 64'(rsp_valid), 64'(vecs[i].ev));
      if (vecs[i].ev) check($sformatf("vec%0d_err", i), 64'(rsp_err), 64'(vecs[i].ee));
      if (vecs[i].ev || vecs[i].wen) check($sformatf("vec%0d_dout", i), 64'(rsp_dout), 64'(vecs[i].ed));
    end

    // Hold register across idle cycles after a read.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, '0, '0, '0);
      check("hold_valid", 64'(rsp_valid), 64'd0);
      check("hold_dout", 64'(rsp_dout), 64'hDEAD_BEEF);
    end

    // Reset arriving with a read in flight drops the response.
    rst = 1'b1;
    drive(1'b1, 1'b0, 12'h7FF, '0, '0);
    check("rstrd_valid", 64'(rsp_valid), 64'd0);
    check("rstrd_dout", 64'(rsp_dout), 64'd0);
    check("rstrd_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    last_dout = 32'h0;
`ifdef SRAM_BANK_CTRL_INIT_EN
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
`endif
    wait_ready("reinit", INIT_CYCLES);
    op("post_rst_rd", 1'b1, 1'b0, 12'h7FF, '0, '0);

    // Randomised mixed traffic against the reference array.
    for (int i = 0; i < 600; i++) begin
      int unsigned kind = $urandom_range(0, 9);
      logic [AW-1:0] a = AW'($urandom_range(0, W + 150));
      logic [31:0] m = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      if (i % 4 == 0) a = AW'($urandom_range(0, 15));
      if (kind < 2) op("rnd_idle", 1'b0, 1'b0, a, '0, '0);
      else if (kind < 6) op("rnd_wr", 1'b1, 1'b1, a, 32'($urandom), m);
      else op("rnd_rd", 1'b1, 1'b0, a, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
